key_expansion: RTL and testbench

KEY_EXPANSION -- requirements
Module: key_expansion

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_sbox.sv | 28 ++
 rtl/key_expansion.sv | 140 ++++++++++++++
 tb/tb_key_expansion.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key schedule constants, round constants and FSM state type
package aes_pkg;

    localparam int NK     = 4;
    localparam int NR     = 10;
    localparam int NWORDS = NK * (NR + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } kx_state_e;

    // Round constant for round 1..10; index 0 and out-of-range return zero
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box, purely combinational byte substitution
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 key schedule generator; KEYEXP_FAST_EN selects one round key per cycle
module key_expansion
    import aes_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [127:0]          Cipherkey,
    output logic [32*NWORDS-1:0]  KeyExp,
    output logic                  Busy,
    output logic                  Done,
    output logic                  KeyValid
);

    localparam int         KW        = 32 * NWORDS;
    localparam logic [5:0] FIRST_CNT = 6'(NK);
    localparam logic [5:0] SAT_CNT   = 6'(NWORDS - 1);
`ifdef KEYEXP_FAST_EN
    localparam logic [5:0] STEP      = 6'(NK);
    localparam logic [5:0] LAST_CNT  = 6'(NK * NR);
`else
    localparam logic [5:0] STEP      = 6'd1;
    localparam logic [5:0] LAST_CNT  = 6'(NWORDS - 1);
`endif

    kx_state_e     state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;        // index of the next word to produce
    logic [KW-1:0] keyexp_q, keyexp_d;
    logic [127:0]  win_q, win_d;        // w(i-4)..w(i-1), oldest word on top
    logic          done_q, done_d;
    logic          valid_q, valid_d;

    logic [KW-1:0] keyexp_upd;
    logic [127:0]  win_upd;
    logic [31:0]   rot_word;
    logic [31:0]   sub_word;
    logic [31:0]   temp_rc;

    // SubWord(RotWord(w(i-1))) is only ever needed for the newest word in the window
    assign rot_word = {win_q[23:0], win_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .data_i (rot_word[8*g +: 8]),
            .data_o (sub_word[8*g +: 8])
        );
    end

    assign temp_rc = sub_word ^ {rcon(cnt_q[5:2]), 24'h0};

`ifdef KEYEXP_FAST_EN
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [127:0] round_key;

    // Whole round key per cycle: four chained XORs from the previous round key
    always_comb begin
        fw0        = win_q[127:96] ^ temp_rc;
        fw1        = win_q[95:64]  ^ fw0;
        fw2        = win_q[63:32]  ^ fw1;
        fw3        = win_q[31:0]   ^ fw2;
        round_key  = {fw0, fw1, fw2, fw3};
        keyexp_upd = keyexp_q;
        // cnt_q = 4r here, so the round key lands at bit 128r = 32*cnt_q
        keyexp_upd[{cnt_q, 5'd0} +: 128] = round_key;
        win_upd    = round_key;
    end
`else
    logic [31:0] temp;
    logic [31:0] w_new;
    logic [10:0] word_base;

    // One word per cycle; word j of round r sits at 128r + 96 - 32j
    always_comb begin
        temp       = (cnt_q[1:0] == 2'b00) ? temp_rc : win_q[31:0];
        w_new      = win_q[127:96] ^ temp;
        word_base  = {cnt_q[5:2], 7'd0} + 11'd96 - {4'd0, cnt_q[1:0], 5'd0};
        keyexp_upd = keyexp_q;
        keyexp_upd[word_base +: 32] = w_new;
        win_upd    = {win_q[95:0], w_new};
    end
`endif

    // Next-state: accept Start only when idle, step the schedule while expanding
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        keyexp_d = keyexp_q;
        win_d    = win_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    keyexp_d = {{(KW-128){1'b0}}, Cipherkey};
                    win_d    = Cipherkey;
                    cnt_d    = FIRST_CNT;
                    valid_d  = 1'b0;
                    state_d  = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                keyexp_d = keyexp_upd;
                win_d    = win_upd;
                if (cnt_q >= LAST_CNT) begin
                    cnt_d   = SAT_CNT;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + STEP;
                end
            end
        endcase
    end

    // State and schedule registers; reset clears everything including a partial schedule
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            keyexp_q <= '0;
            win_q    <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            keyexp_q <= keyexp_d;
            win_q    <= win_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    assign KeyExp   = keyexp_q;
    assign Busy     = (state_q == ST_EXPAND);
    assign Done     = done_q;
    assign KeyValid = valid_q;

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - self-checking bench for key_expansion against a GF(2^8)-derived reference schedule
module tb_key_expansion;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           Start = 1'b0;
    logic [127:0]   Cipherkey = '0;
    logic [1407:0]  KeyExp;
    logic           Busy;
    logic           Done;
    logic           KeyValid;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

`ifdef KEYEXP_FAST_EN
    localparam int EXP_LAT    = 10;
    localparam int RESTART_AT = 5;
    localparam int RST_AT     = 5;
`else
    localparam int EXP_LAT    = 40;
    localparam int RESTART_AT = 10;
    localparam int RST_AT     = 20;
`endif

    always #5 Clk = ~Clk;

    key_expansion dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Cipherkey (Cipherkey),
        .KeyExp    (KeyExp),
        .Busy      (Busy),
        .Done      (Done),
        .KeyValid  (KeyValid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input logic [127:0] key, output logic [1407:0] ks);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[128*(i/4) + 96 - 32*(i%4) +: 32] = w[i];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_sched(input string tag, input logic [127:0] key);
        logic [1407:0] ks;
        ref_expand(key, ks);
        for (int r = 0; r < 11; r++)
            check($sformatf("%s_rk%0d", tag, r), KeyExp[128*r +: 128], ks[128*r +: 128]);
    endtask

    // Waits for Done; lat counts negedges after the accept edge, -1 on timeout
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!Done && lat < 200);
        if (!Done) lat = -1;
    endtask

    task automatic run_exp(input string tag, input logic [127:0] key);
        int lat;
        @(negedge Clk);
        Cipherkey = key;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Cipherkey = rand128();
        check({tag, "_busy"}, 128'(Busy), 128'(1));
        check({tag, "_kv_low"}, 128'(KeyValid), 128'(0));
        wait_done(lat);
        check({tag, "_latency"}, 128'(lat), 128'(EXP_LAT));
        check({tag, "_idle"}, 128'(Busy), 128'(0));
        check({tag, "_kv"}, 128'(KeyValid), 128'(1));
        check_sched(tag, key);
        @(negedge Clk);
        check({tag, "_done_pulse"}, 128'(Done), 128'(0));
    endtask

    initial begin
        int lat;
        int dones;
        logic [127:0] ka, kb;
        build_sbox();

        repeat (2) @(negedge Clk);
        check("rst_keyexp", 128'(|KeyExp), 128'(0));
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_done", 128'(Done), 128'(0));
        check("rst_kv", 128'(KeyValid), 128'(0));
        Reset_n = 1'b1;

        run_exp("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("fips_rk1_const", KeyExp[255:128], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk10_const", KeyExp[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_exp("zero", 128'h0);
        check("zero_rk1_const", KeyExp[255:128], 128'h62636363626363636263636362636363);
        check("zero_rk10_const", KeyExp[1407:1280], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int n = 0; n < 6; n++) run_exp($sformatf("rnd%0d", n), rand128());

        // Start re-pulsed mid-expansion with another key, and Cipherkey left changed
        ka = rand128();
        kb = rand128();
        @(negedge Clk);
        Cipherkey = ka;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        dones = 0;
        for (int k = 0; k < EXP_LAT + 30; k++) begin
            @(negedge Clk);
            if (Start) Start = 1'b0;
            if (Done) dones++;
            if (k + 1 == RESTART_AT) begin
                check("ign_busy", 128'(Busy), 128'(1));
                Start = 1'b1;
                Cipherkey = kb;
            end
        end
        check("ign_done_count", 128'(dones), 128'(1));
        check("ign_kv_hold", 128'(KeyValid), 128'(1));
        check_sched("ign", ka);

        // Asynchronous reset in the middle of an expansion
        @(negedge Clk);
        Cipherkey = rand128();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (RST_AT - 1) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_keyexp", 128'(|KeyExp), 128'(0));
        check("arst_busy", 128'(Busy), 128'(0));
        check("arst_done", 128'(Done), 128'(0));
        check("arst_kv", 128'(KeyValid), 128'(0));
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (EXP_LAT) @(negedge Clk);
        check("arst_no_valid", 128'(KeyValid), 128'(0));
        check("arst_no_done", 128'(Done), 128'(0));
        run_exp("post_rst", rand128());

        // Start held high: back-to-back expansions
        ka = rand128();
        @(negedge Clk);
        Cipherkey = ka;
        Start = 1'b1;
        @(negedge Clk);
        check("b2b_kv_low1", 128'(KeyValid), 128'(0));
        wait_done(lat);
        check("b2b_latency1", 128'(lat), 128'(EXP_LAT));
        check_sched("b2b_first", ka);
        @(negedge Clk);
        check("b2b_restart_busy", 128'(Busy), 128'(1));
        check("b2b_kv_low2", 128'(KeyValid), 128'(0));
        wait_done(lat);
        check("b2b_period", 128'(lat + 1), 128'(EXP_LAT + 1));
        Start = 1'b0;
        @(negedge Clk);
        check("b2b_stop", 128'(Busy), 128'(0));
        check_sched("b2b_second", ka);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
